slv_guard_rst_ctrl: RTL and testbench
=====================================

Name: slv_guard_rst_ctrl

Overview:
Reset sequencer for the subordinate guard. It collects per-subordinate fault requests raised by the write/read guard monitors and arbitrates among them round-robin. For one subordinate at a time it runs: isolate, drain, reset handshake, release. It sits between the guard monitors and the per-subordinate reset/isolation logic, and raises the guard interrupt when a sequence finishes.

Parameters:
NumSub, 2, number of guarded subordinates (1..32)
CntWidth, 16, width of drain/ack budget counters
MinRstCycles, 4, minimum cycles rst_req_o stays asserted (>=1, < 2**CntWidth)
IdxWidth, cf_math_pkg::idx_width(NumSub), width of subordinate index (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
ctrl_en_i  in  1  controller enable; 0 = no new sequence starts
fault_i  in  NumSub  per-subordinate reset request pulse/level from monitors
idle_i  in  NumSub  subordinate k has zero outstanding transactions
drain_budget_i  in  CntWidth  max cycles to wait for idle_i in DRAIN
ack_budget_i  in  CntWidth  max cycles to wait for each rst_stat_i edge
isolate_o  out  NumSub  block new AW/AR to subordinate k, error-respond locally
rst_req_o  out  NumSub  reset request to subordinate k
rst_stat_i  in  NumSub  reset status from subordinate k (1 = in reset)
pending_o  out  NumSub  captured, not yet serviced requests
busy_o  out  1  sequence in progress
irq_o  out  1  one-cycle pulse at sequence end
irq_id_o  out  IdxWidth  index of subordinate whose sequence ended (held until next irq)
irq_err_o  out  1  with irq_o: 1 if a drain or ack budget expired (held with irq_id_o)

Behaviour:
- Reset: FSM=IDLE; pending, counters, rr pointer=0; all outputs 0.
- Capture: pending[k] <= pending[k] | fault_i[k] every cycle. Clear pending[k] only on the IDLE->ISOLATE grant of k. A fault_i[k] in the grant cycle is absorbed; a fault during the sequence of k re-sets pending[k].
- Arbitration in IDLE: if ctrl_en_i && |pending, grant the first set bit at or after rr pointer (wrapping). Latch sel=k; rr pointer <= (k+1) mod NumSub.
- ISOLATE (1 cycle): isolate_o[sel]=1 from this state until IDLE re-entry. Cnt<=0. -> DRAIN.
- DRAIN: if idle_i[sel] -> ASSERT. Else if cnt==drain_budget_i, set err flag and -> ASSERT (forced reset). Else cnt++.
- ASSERT: rst_req_o[sel]=1. Cnt counts from 0. Leave once cnt>=MinRstCycles-1 AND rst_stat_i[sel]=1 -> DEASSERT, cnt<=0. If cnt reaches ack_budget_i + MinRstCycles - 1 without rst_stat high: set err, -> DEASSERT.
- DEASSERT: rst_req_o[sel]=0. Wait rst_stat_i[sel]=0 -> DONE. Budget ack_budget_i; on expiry set err, -> DONE.
- DONE (1 cycle): irq_o=1, irq_id_o<=sel, irq_err_o<=err, err<=0. Drop isolate_o. -> IDLE.
- busy_o=1 in all states except IDLE. Latency: fault in cycle t with idle controller and idle subordinate -> isolate_o at t+2, rst_req_o at t+4.
- Counters saturate; never wrap. Budget 0 = expire on first check cycle.
- ctrl_en_i deassert mid-sequence does not abort; it only blocks the next grant.
- Only one bit of isolate_o/rst_req_o is ever set. All outputs are registered.
- rst_i mid-sequence: immediate return to reset values. Subordinate reset released combinationally with rst_i.

Optional Feature:
SLV_GUARD_RST_CTRL_STATS_EN:
- When defined: adds port rst_cnt_o (out, NumSub*8). Per-subordinate saturating (255) count of completed sequences, incremented in DONE. Also adds err_cnt_o (out, NumSub*8), incremented when err is set. Both reset to 0.
- When undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- NumSub=2, idle_i=2'b11, fault_i[1] pulse at t=10, rst_stat_i follows rst_req_o with 2-cycle delay -> isolate_o=2'b10 at t=12, rst_req_o[1] t=14..t=17, irq_o at t=21, irq_id_o=1, irq_err_o=0.
- Simultaneous fault_i=2'b11, rr=0 -> sub0 serviced first, then sub1. Exactly two irq pulses, ids 0 then 1; pending_o=2'b10 during the first sequence.
- idle_i[0]=0 held, drain_budget_i=5 -> DRAIN lasts 6 cycles, reset proceeds, irq_err_o=1.
- rst_stat_i stuck 0, ack_budget_i=3, MinRstCycles=4 -> rst_req_o high 7 cycles, irq_err_o=1, controller returns IDLE.
- ctrl_en_i=0 with fault_i[0]=1 -> pending_o=2'b01, busy_o=0. Raise ctrl_en_i -> sequence starts next cycle.
- rst_i asserted in ASSERT state -> all outputs 0 same cycle, pending_o=0; resumes normally after release.

Source files
------------

// File: rtl/slv_guard_rst_ctrl_if.sv
// Signal bundle between the guard monitors, the reset sequencer and the
// per-subordinate reset/isolation logic. The statistics outputs exist only
// when SLV_GUARD_RST_CTRL_STATS_EN is defined.
interface slv_guard_rst_ctrl_if #(
   parameter int unsigned NumSub   = 2,
   parameter int unsigned CntWidth = 16,
   parameter int unsigned IdxWidth = 1
);
   logic                ctrl_en_i;
   logic [NumSub-1:0]   fault_i;
   logic [NumSub-1:0]   idle_i;
   logic [CntWidth-1:0] drain_budget_i;
   logic [CntWidth-1:0] ack_budget_i;
   logic [NumSub-1:0]   rst_stat_i;
   logic [NumSub-1:0]   isolate_o;
   logic [NumSub-1:0]   rst_req_o;
   logic [NumSub-1:0]   pending_o;
   logic                busy_o;
   logic                irq_o;
   logic [IdxWidth-1:0] irq_id_o;
   logic                irq_err_o;
`ifdef SLV_GUARD_RST_CTRL_STATS_EN
   logic [NumSub*8-1:0] rst_cnt_o;
   logic [NumSub*8-1:0] err_cnt_o;
`endif

   modport master (
      output ctrl_en_i, fault_i, idle_i, drain_budget_i, ack_budget_i, rst_stat_i,
`ifdef SLV_GUARD_RST_CTRL_STATS_EN
      input  rst_cnt_o, err_cnt_o,
`endif
      input  isolate_o, rst_req_o, pending_o, busy_o, irq_o, irq_id_o, irq_err_o
   );

   modport slave (
      input  ctrl_en_i, fault_i, idle_i, drain_budget_i, ack_budget_i, rst_stat_i,
`ifdef SLV_GUARD_RST_CTRL_STATS_EN
      output rst_cnt_o, err_cnt_o,
`endif
      output isolate_o, rst_req_o, pending_o, busy_o, irq_o, irq_id_o, irq_err_o
   );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// Subordinate guard reset sequencer: captures per-subordinate fault requests,
// grants them round-robin and runs isolate -> drain -> reset handshake ->
// release for one subordinate at a time, pulsing irq at the end.
// Optional per-subordinate statistics: define SLV_GUARD_RST_CTRL_STATS_EN.
module slv_guard_rst_ctrl #(
   parameter int unsigned  NumSub       = 2,
   parameter int unsigned  CntWidth     = 16,
   parameter int unsigned  MinRstCycles = 4,
   localparam int unsigned IdxWidth     = (NumSub > 1) ? $clog2(NumSub) : 1
) (
   input logic                 clk_i,
   input logic                 rst_i,
   slv_guard_rst_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISOLATE  = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_ASSERT   = 3'd3,
      ST_DEASSERT = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // Last ASSERT count at which the minimum reset width is satisfied.
   localparam logic [CntWidth:0] MinHold = (CntWidth+1)'(MinRstCycles - 1);

   state_t              state;
   logic [NumSub-1:0]   pending, isolate, rst_req;
   logic [IdxWidth-1:0] sel, rr, irq_id;
   logic [CntWidth-1:0] cnt;
   logic                err, busy, irq, irq_err;

   logic                grant_vld, grant_take;
   logic [IdxWidth-1:0] grant_idx;
   logic [NumSub-1:0]   pend_nxt, sel_mask;
   logic [CntWidth-1:0] cnt_inc;
   logic [CntWidth:0]   ast_limit;
   logic                drain_done, drain_exp, ast_done, ast_exp, deast_done, deast_exp, err_evt;

   // (idx + ofs) mod NumSub for ofs < NumSub
   function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] idx,
                                                    input int unsigned ofs);
      int unsigned sum;
      sum = 32'(idx) + ofs;
      if (sum >= NumSub) sum = sum - NumSub;
      else               sum = sum;
      return IdxWidth'(sum);
   endfunction

   function automatic logic [NumSub-1:0] onehot(input logic [IdxWidth-1:0] idx);
      logic [NumSub-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search for the first pending request at or after rr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NumSub; i++) begin
         if (!grant_vld && pending[wrap_add(rr, i)]) begin
            grant_vld = 1'b1;
            grant_idx = wrap_add(rr, i);
         end else begin
            grant_vld = grant_vld;
         end
      end
      grant_take = (state == ST_IDLE) && bus.ctrl_en_i && grant_vld;
      // a fault arriving in the grant cycle of the same subordinate is absorbed
      pend_nxt   = (pending | bus.fault_i) & ~(grant_take ? onehot(grant_idx) : '0);
   end

   // Phase exit conditions and budget expiry; the counter saturates.
   always_comb begin
      sel_mask   = onehot(sel);
      cnt_inc    = (cnt == {CntWidth{1'b1}}) ? cnt : cnt + CntWidth'(1);
      ast_limit  = {1'b0, bus.ack_budget_i} + MinHold;
      drain_done = bus.idle_i[sel];
      drain_exp  = !drain_done && (cnt >= bus.drain_budget_i);
      ast_done   = ({1'b0, cnt} >= MinHold) && bus.rst_stat_i[sel];
      ast_exp    = !ast_done && ({1'b0, cnt} >= ast_limit);
      deast_done = !bus.rst_stat_i[sel];
      deast_exp  = !deast_done && (cnt >= bus.ack_budget_i);
      case (state)
         ST_DRAIN:    err_evt = drain_exp;
         ST_ASSERT:   err_evt = ast_exp;
         ST_DEASSERT: err_evt = deast_exp;
         default:     err_evt = 1'b0;
      endcase
   end

   // Sequencer FSM with request capture and all registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         pending <= '0;
         sel     <= '0;
         rr      <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         isolate <= '0;
         rst_req <= '0;
         busy    <= 1'b0;
         irq     <= 1'b0;
         irq_id  <= '0;
         irq_err <= 1'b0;
      end else begin
         pending <= pend_nxt;
         irq     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_take) begin
                  state   <= ST_ISOLATE;
                  sel     <= grant_idx;
                  rr      <= wrap_add(grant_idx, 32'd1);
                  isolate <= onehot(grant_idx);
                  busy    <= 1'b1;
               end
            end
            ST_ISOLATE: begin
               cnt   <= '0;
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_done || drain_exp) begin
                  state   <= ST_ASSERT;
                  cnt     <= '0;
                  rst_req <= sel_mask;
                  err     <= err | drain_exp;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_ASSERT: begin
               if (ast_done || ast_exp) begin
                  state   <= ST_DEASSERT;
                  cnt     <= '0;
                  rst_req <= '0;
                  err     <= err | ast_exp;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_DEASSERT: begin
               if (deast_done || deast_exp) begin
                  state   <= ST_DONE;
                  irq     <= 1'b1;
                  irq_id  <= sel;
                  irq_err <= err | deast_exp;
                  err     <= err | deast_exp;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               isolate <= '0;
               busy    <= 1'b0;
               err     <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               isolate <= '0;
               rst_req <= '0;
               busy    <= 1'b0;
               err     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.isolate_o = isolate;
   assign bus.rst_req_o = rst_req;
   assign bus.pending_o = pending;
   assign bus.busy_o    = busy;
   assign bus.irq_o     = irq;
   assign bus.irq_id_o  = irq_id;
   assign bus.irq_err_o = irq_err;

`ifdef SLV_GUARD_RST_CTRL_STATS_EN
   logic [7:0] rst_cnt [NumSub];
   logic [7:0] err_cnt [NumSub];

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Per-subordinate saturating counts of completed sequences and budget expiries.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NumSub; k++) begin
            rst_cnt[k] <= 8'd0;
            err_cnt[k] <= 8'd0;
         end
      end else begin
         if (state == ST_DONE) rst_cnt[sel] <= sat_inc8(rst_cnt[sel]);
         if (err_evt)          err_cnt[sel] <= sat_inc8(err_cnt[sel]);
      end
   end

   for (genvar k = 0; k < NumSub; k++) begin : g_stats
      assign bus.rst_cnt_o[k*8 +: 8] = rst_cnt[k];
      assign bus.err_cnt_o[k*8 +: 8] = err_cnt[k];
   end
`endif
endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl. A sequence-level model predicts, at
// each grant, the cycle window of every phase from the budgets and the
// emulated subordinate behaviour; outputs are compared every cycle on the
// falling edge. Literal expectations pin the key latencies.
module tb_slv_guard_rst_ctrl;
   localparam int NS   = 2;
   localparam int CW   = 16;
   localparam int MR   = 4;
   localparam int IW   = 1;
   localparam int DLY  = 2;                          // subordinate status lag
   localparam int NEED = (MR - 1 > DLY) ? MR - 1 : DLY;

   logic clk = 1'b0;
   logic rst = 1'b1;

   slv_guard_rst_ctrl_if #(.NumSub(NS), .CntWidth(CW), .IdxWidth(IW)) bus ();

   slv_guard_rst_ctrl #(.NumSub(NS), .CntWidth(CW), .MinRstCycles(MR)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int chk_en   = 0;
   int s_mode   = 0;   // 0: status follows request with DLY lag, 1: stuck at 0

   logic [NS-1:0] h1 = '0, h2 = '0;

   // model state
   logic [NS-1:0] m_pend = '0, pend_in;
   int   m_rr = 0, m_active = 0, m_sub = 0, m_err = 0;
   int   t_iso = 0, t_ast = 0, t_deast = 0, t_done = 0;
   int   m_irq_id = 0, m_irq_err = 0;
   int   act, k, found, dl, al, dlen, lim, ackb;
   logic [NS-1:0] e_iso, e_req;

   // observations for literal checks
   logic [NS-1:0] prev_iso = '0, prev_req = '0;
   int   o_iso_rise = -1, o_req_rise = -1, o_req_last = -1, o_irq_cyc = -1, o_irq_n = 0;
   int   o_irq_ids [16];

   int   t0, t1, n0;

   task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act_v, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Subordinate emulation: status follows the reset request DLY cycles later.
   initial begin
      bus.rst_stat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.rst_stat_i = (s_mode == 0) ? h2 : '0;
      end
   end

   // Per-cycle model comparison, observation capture and model advance.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (chk_en != 0) begin
               check("rst_isolate", bus.isolate_o, 0);
               check("rst_req",     bus.rst_req_o, 0);
               check("rst_pending", bus.pending_o, 0);
               check("rst_busy",    bus.busy_o, 0);
               check("rst_irq",     bus.irq_o, 0);
               check("rst_irq_id",  bus.irq_id_o, 0);
               check("rst_irq_err", bus.irq_err_o, 0);
            end
            m_pend = '0; m_rr = 0; m_active = 0; m_irq_id = 0; m_irq_err = 0;
         end else begin
            act = (m_active != 0 && cyc >= t_iso && cyc <= t_done) ? 1 : 0;
            if (m_active != 0 && cyc == t_done) begin
               m_irq_id  = m_sub;
               m_irq_err = m_err;
            end
            e_iso = (act != 0) ? NS'(1 << m_sub) : '0;
            e_req = (m_active != 0 && cyc >= t_ast && cyc < t_deast) ? NS'(1 << m_sub) : '0;
            if (chk_en != 0) begin
               check("isolate", bus.isolate_o, e_iso);
               check("rst_req", bus.rst_req_o, e_req);
               check("pending", bus.pending_o, m_pend);
               check("busy",    bus.busy_o, act);
               check("irq",     bus.irq_o, (m_active != 0 && cyc == t_done) ? 1 : 0);
               check("irq_id",  bus.irq_id_o, m_irq_id);
               check("irq_err", bus.irq_err_o, m_irq_err);
            end
            if (m_active != 0 && cyc == t_done) m_active = 0;
            pend_in = m_pend | bus.fault_i;
            if (act == 0 && bus.ctrl_en_i && m_pend != '0) begin
               found = 0;
               k = 0;
               for (int i = 0; i < NS; i++) begin
                  if (found == 0 && m_pend[(m_rr + i) % NS]) begin
                     found = 1;
                     k = (m_rr + i) % NS;
                  end
               end
               m_rr = (k + 1) % NS;
               pend_in[k] = 1'b0;
               m_active = 1; m_sub = k; m_err = 0;
               t_iso = cyc + 1;
               ackb  = int'(bus.ack_budget_i);
               if (bus.idle_i[k]) dl = 1;
               else begin dl = int'(bus.drain_budget_i) + 1; m_err = 1; end
               t_ast = cyc + 2 + dl;
               lim = ackb + MR - 1;
               if (s_mode == 0 && NEED <= lim) al = NEED + 1;
               else begin al = lim + 1; m_err = 1; end
               t_deast = t_ast + al;
               if (s_mode != 0) dlen = 1;
               else if (DLY <= ackb) dlen = DLY + 1;
               else begin dlen = ackb + 1; m_err = 1; end
               t_done = t_deast + dlen;
            end
            m_pend = pend_in;
         end
         if (bus.isolate_o != '0 && prev_iso == '0) o_iso_rise = cyc;
         if (bus.rst_req_o != '0) begin
            if (prev_req == '0) o_req_rise = cyc;
            o_req_last = cyc;
         end
         if (bus.irq_o) begin
            o_irq_cyc = cyc;
            if (o_irq_n < 16) o_irq_ids[o_irq_n] = int'(bus.irq_id_o);
            o_irq_n++;
         end
         prev_iso = bus.isolate_o;
         prev_req = bus.rst_req_o;
         h2 = h1;
         h1 = bus.rst_req_o;
         cyc++;
      end
   end

   // Directed stimulus with literal expectations.
   initial begin
      bus.ctrl_en_i      = 1'b1;
      bus.fault_i        = '0;
      bus.idle_i         = 2'b11;
      bus.drain_budget_i = 16'd8;
      bus.ack_budget_i   = 16'd8;
      step(1);
      chk_en = 1;
      step(2);
      rst = 1'b0;
      step(2);

      // single fault on sub1, compliant subordinate
      t0 = cyc; n0 = o_irq_n;
      bus.fault_i = 2'b10; step(1); bus.fault_i = '0;
      step(25);
      check("t1_iso_rise", o_iso_rise, t0 + 2);
      check("t1_req_rise", o_req_rise, t0 + 4);
      check("t1_req_last", o_req_last, t0 + 7);
      check("t1_irq_cyc",  o_irq_cyc,  t0 + 11);
      check("t1_irq_n",    o_irq_n - n0, 1);
      check("t1_irq_id",   bus.irq_id_o, 1);
      check("t1_irq_err",  bus.irq_err_o, 0);

      // simultaneous faults: sub0 then sub1
      t0 = cyc; n0 = o_irq_n;
      bus.fault_i = 2'b11; step(1); bus.fault_i = '0;
      step(4); #2;
      check("t2_pending_mid", bus.pending_o, 2'b10);
      step(25);
      check("t2_irq_n",   o_irq_n - n0, 2);
      check("t2_first",   o_irq_ids[n0], 0);
      check("t2_second",  o_irq_ids[n0 + 1], 1);

      // sub0 never idle: drain budget 5 expires
      bus.idle_i = 2'b10; bus.drain_budget_i = 16'd5;
      t0 = cyc;
      bus.fault_i = 2'b01; step(1); bus.fault_i = '0;
      step(24);
      check("t3_iso_rise", o_iso_rise, t0 + 2);
      check("t3_req_rise", o_req_rise, t0 + 9);
      check("t3_irq_cyc",  o_irq_cyc,  t0 + 16);
      check("t3_irq_id",   bus.irq_id_o, 0);
      check("t3_irq_err",  bus.irq_err_o, 1);
      bus.idle_i = 2'b11; bus.drain_budget_i = 16'd8;

      // reset status stuck low, ack budget 3
      s_mode = 1; bus.ack_budget_i = 16'd3;
      t0 = cyc;
      bus.fault_i = 2'b10; step(1); bus.fault_i = '0;
      step(20);
      check("t4_req_rise", o_req_rise, t0 + 4);
      check("t4_req_last", o_req_last, t0 + 10);
      check("t4_irq_cyc",  o_irq_cyc,  t0 + 12);
      check("t4_irq_err",  bus.irq_err_o, 1);
      check("t4_busy",     bus.busy_o, 0);
      s_mode = 0; bus.ack_budget_i = 16'd8;
      step(3);

      // controller disabled: request waits, then starts one cycle after enable
      bus.ctrl_en_i = 1'b0;
      bus.fault_i = 2'b01; step(1); bus.fault_i = '0;
      step(3); #2;
      check("t5_pending", bus.pending_o, 2'b01);
      check("t5_busy",    bus.busy_o, 0);
      step(1);
      bus.ctrl_en_i = 1'b1;
      step(1); #2;
      check("t5_isolate", bus.isolate_o, 2'b01);
      check("t5_busy_on", bus.busy_o, 1);
      step(20);

      // reset during ASSERT, then normal operation resumes
      t0 = cyc;
      bus.fault_i = 2'b10; step(1); bus.fault_i = '0;
      step(2);
      bus.fault_i = 2'b01; step(1); bus.fault_i = '0;
      step(1);
      check("t6_pre_req",  bus.rst_req_o, 2'b10);
      check("t6_pre_pend", bus.pending_o, 2'b01);
      rst = 1'b1;
      #1;
      check("t6_isolate", bus.isolate_o, 0);
      check("t6_req",     bus.rst_req_o, 0);
      check("t6_pending", bus.pending_o, 0);
      check("t6_busy",    bus.busy_o, 0);
      step(2);
      rst = 1'b0;
      step(2);
      t1 = cyc;
      bus.fault_i = 2'b01; step(1); bus.fault_i = '0;
      step(25);
      check("t6_req_rise", o_req_rise, t1 + 4);
      check("t6_irq_cyc",  o_irq_cyc,  t1 + 11);
      check("t6_irq_id",   bus.irq_id_o, 0);
      check("t6_irq_err",  bus.irq_err_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
